// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: decode-side handshake plus the instruction ROM port.
//   master (fetch stage): drives imem_addr, instruction, pc, pc_plus4,
//                         instr_valid, misaligned; receives stall,
//                         branch_taken, branch_target, imem_rdata.
//   slave  (decode + ROM): the mirror image.
interface instr_fetch_if #(
    parameter int unsigned IMEM_AW = 14
);
    logic               stall;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        instruction;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic               instr_valid;
    logic               misaligned;

    modport master (
        input  stall, branch_taken, branch_target, imem_rdata,
        output imem_addr, instruction, pc, pc_plus4, instr_valid, misaligned
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_rdata,
        input  imem_addr, instruction, pc, pc_plus4, instr_valid, misaligned
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency ROM, holds
// the current word across decode stalls and redirects with a one-cycle bubble.
//   clk, reset : clock, synchronous active-high reset
//   bus        : instr_fetch_if.master (stall/branch inputs, ROM port, decode outputs)
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 14
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] WORD_STEP = 32'd4;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        hold_valid_q, hold_valid_d;
    logic        mis_q, mis_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            fpc_q        <= RESET_PC;
            pc_q         <= RESET_PC;
            hold_instr_q <= 32'h0;
            hold_valid_q <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            hold_valid_q <= hold_valid_d;
            mis_q        <= mis_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        hold_valid_d = hold_valid_q;
        mis_d        = mis_q;
        case (state_q)
            FILL: begin
                // Word for fpc is in flight; it becomes the presented instruction.
                pc_d    = fpc_q;
                fpc_d   = fpc_q + WORD_STEP;
                state_d = RUN;
            end
            RUN: begin
                if (bus.stall) begin
                    // ROM moves on to mem[fpc] next cycle, so capture the
                    // presented word once and replay it until release.
                    if (!hold_valid_q) begin
                        hold_instr_d = bus.imem_rdata;
                        hold_valid_d = 1'b1;
                    end
                end else if (bus.branch_taken) begin
                    fpc_d        = {bus.branch_target[31:2], 2'b00};
                    hold_valid_d = 1'b0;
                    state_d      = FILL;
                    if (bus.branch_target[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end
                end else begin
                    pc_d         = fpc_q;
                    fpc_d        = fpc_q + WORD_STEP;
                    hold_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Outputs: all derived from registers except the ROM data mux
    assign bus.imem_addr   = fpc_q[IMEM_AW+1:2];
    assign bus.instr_valid = (state_q == RUN);
    assign bus.instruction = (state_q != RUN) ? NOP
                           : (hold_valid_q ? hold_instr_q : bus.imem_rdata);
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + WORD_STEP;
    assign bus.misaligned  = mis_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenario tables plus a randomized run
// against a transaction-level model of the fetched instruction stream.
module tb_instr_fetch;
    localparam int unsigned AW = 14;

    typedef struct {
        bit          rst;
        bit          st;
        bit          bt;
        logic [31:0] tgt;
        bit          chk;
        bit          ev;
        logic [31:0] epc;
        bit          em;
    } row_t;

    logic clk;
    logic reset;
    logic [31:0] rom [0:(1<<AW)-1];
    int checks;
    int passes;

    bit          m_valid;
    bit          m_mis;
    logic [31:0] m_pc;
    logic [31:0] m_next;

    instr_fetch_if #(.IMEM_AW(AW)) bus ();

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle read latency
    always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

    function automatic row_t mk(input bit rst, input bit st, input bit bt, input logic [31:0] tgt,
                                input bit chk, input bit ev, input logic [31:0] epc, input bit em);
        row_t r;
        r.rst = rst; r.st = st; r.bt = bt; r.tgt = tgt;
        r.chk = chk; r.ev = ev; r.epc = epc; r.em = em;
        return r;
    endfunction

    // Expected decode-side word for a given presented pc
    function automatic logic [31:0] exp_instr(input bit ev, input logic [31:0] epc);
        logic [31:0] idx;
        idx = (epc >> 2) & ((32'd1 << AW) - 32'd1);
        return ev ? (32'hA000_0000 | idx) : 32'h0000_0013;
    endfunction

    task automatic drive(input bit rst, input bit st, input bit bt, input logic [31:0] tgt);
        reset             = rst;
        bus.stall         = st;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: a stream of words, one bubble after reset or an accepted redirect
    task automatic model_step();
        if (reset) begin
            m_valid = 1'b0;
            m_next  = 32'h0;
            m_mis   = 1'b0;
        end else if (!m_valid) begin
            m_valid = 1'b1;
            m_pc    = m_next;
        end else if (bus.stall) begin
            m_valid = 1'b1;
        end else if (bus.branch_taken) begin
            m_valid = 1'b0;
            m_next  = bus.branch_target & 32'hFFFF_FFFC;
            if (bus.branch_target[1:0] != 2'b00) m_mis = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic test_reset();
        row_t rows[$];
        rows.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0, 0));
        rows.push_back(mk(1, 0, 0, 32'h0,  1, 0, 32'h0, 0));
        rows.push_back(mk(1, 1, 1, 32'h44, 1, 0, 32'h0, 0));
        foreach (rows[i]) begin
            drive(rows[i].rst, rows[i].st, rows[i].bt, rows[i].tgt);
            if (rows[i].chk) begin
                checks++;
                if (bus.instr_valid !== rows[i].ev || bus.misaligned !== rows[i].em ||
                    bus.instruction !== exp_instr(rows[i].ev, rows[i].epc) ||
                    (rows[i].ev && (bus.pc !== rows[i].epc || bus.pc_plus4 !== rows[i].epc + 32'd4)))
                    $display("FAIL reset row %0d: valid=%b pc=%h instr=%h mis=%b, want valid=%b pc=%h instr=%h mis=%b",
                             i, bus.instr_valid, bus.pc, bus.instruction, bus.misaligned,
                             rows[i].ev, rows[i].epc, exp_instr(rows[i].ev, rows[i].epc), rows[i].em);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_sequential();
        row_t rows[$];
        rows.push_back(mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 0));
        for (int k = 0; k < 4; k++) rows.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'(4 * k), 0));
        foreach (rows[i]) begin
            drive(rows[i].rst, rows[i].st, rows[i].bt, rows[i].tgt);
            if (rows[i].chk) begin
                checks++;
                if (bus.instr_valid !== rows[i].ev || bus.misaligned !== rows[i].em ||
                    bus.instruction !== exp_instr(rows[i].ev, rows[i].epc) ||
                    (rows[i].ev && (bus.pc !== rows[i].epc || bus.pc_plus4 !== rows[i].epc + 32'd4)))
                    $display("FAIL sequential row %0d: valid=%b pc=%h instr=%h mis=%b, want valid=%b pc=%h instr=%h mis=%b",
                             i, bus.instr_valid, bus.pc, bus.instruction, bus.misaligned,
                             rows[i].ev, rows[i].epc, exp_instr(rows[i].ev, rows[i].epc), rows[i].em);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        row_t rows[$];
        rows.push_back(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 0));
        rows.push_back(mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 0));
        rows.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'h0, 0));
        rows.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'h4, 0));
        rows.push_back(mk(0, 1, 0, 32'h0, 1, 1, 32'h8, 0));
        rows.push_back(mk(0, 1, 0, 32'h0, 1, 1, 32'h8, 0));
        rows.push_back(mk(0, 1, 0, 32'h0, 1, 1, 32'h8, 0));
        rows.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'h8, 0));
        rows.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'hC, 0));
        rows.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'h10, 0));
        foreach (rows[i]) begin
            drive(rows[i].rst, rows[i].st, rows[i].bt, rows[i].tgt);
            if (rows[i].chk) begin
                checks++;
                if (bus.instr_valid !== rows[i].ev || bus.misaligned !== rows[i].em ||
                    bus.instruction !== exp_instr(rows[i].ev, rows[i].epc) ||
                    (rows[i].ev && (bus.pc !== rows[i].epc || bus.pc_plus4 !== rows[i].epc + 32'd4)))
                    $display("FAIL stall row %0d: valid=%b pc=%h instr=%h mis=%b, want valid=%b pc=%h instr=%h mis=%b",
                             i, bus.instr_valid, bus.pc, bus.instruction, bus.misaligned,
                             rows[i].ev, rows[i].epc, exp_instr(rows[i].ev, rows[i].epc), rows[i].em);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        rows.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h0,  0));
        rows.push_back(mk(0, 0, 1, 32'h40, 1, 1, 32'h4,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h40, 0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h44, 0));
        foreach (rows[i]) begin
            drive(rows[i].rst, rows[i].st, rows[i].bt, rows[i].tgt);
            if (rows[i].chk) begin
                checks++;
                if (bus.instr_valid !== rows[i].ev || bus.misaligned !== rows[i].em ||
                    bus.instruction !== exp_instr(rows[i].ev, rows[i].epc) ||
                    (rows[i].ev && (bus.pc !== rows[i].epc || bus.pc_plus4 !== rows[i].epc + 32'd4)))
                    $display("FAIL branch row %0d: valid=%b pc=%h instr=%h mis=%b, want valid=%b pc=%h instr=%h mis=%b",
                             i, bus.instr_valid, bus.pc, bus.instruction, bus.misaligned,
                             rows[i].ev, rows[i].epc, exp_instr(rows[i].ev, rows[i].epc), rows[i].em);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_stall_branch();
        row_t rows[$];
        rows.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h4,  0));
        rows.push_back(mk(0, 1, 1, 32'h80, 1, 1, 32'h8,  0));
        rows.push_back(mk(0, 1, 1, 32'h80, 1, 1, 32'h8,  0));
        rows.push_back(mk(0, 0, 1, 32'h80, 1, 1, 32'h8,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h80, 0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h84, 0));
        foreach (rows[i]) begin
            drive(rows[i].rst, rows[i].st, rows[i].bt, rows[i].tgt);
            if (rows[i].chk) begin
                checks++;
                if (bus.instr_valid !== rows[i].ev || bus.misaligned !== rows[i].em ||
                    bus.instruction !== exp_instr(rows[i].ev, rows[i].epc) ||
                    (rows[i].ev && (bus.pc !== rows[i].epc || bus.pc_plus4 !== rows[i].epc + 32'd4)))
                    $display("FAIL stall_branch row %0d: valid=%b pc=%h instr=%h mis=%b, want valid=%b pc=%h instr=%h mis=%b",
                             i, bus.instr_valid, bus.pc, bus.instruction, bus.misaligned,
                             rows[i].ev, rows[i].epc, exp_instr(rows[i].ev, rows[i].epc), rows[i].em);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_misaligned();
        row_t rows[$];
        rows.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 1, 32'h42, 1, 1, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 0, 32'h0,  1));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h40, 1));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h44, 1));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h48, 1));
        rows.push_back(mk(1, 0, 0, 32'h0,  1, 1, 32'h4C, 1));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 0, 32'h0,  0));
        foreach (rows[i]) begin
            drive(rows[i].rst, rows[i].st, rows[i].bt, rows[i].tgt);
            if (rows[i].chk) begin
                checks++;
                if (bus.instr_valid !== rows[i].ev || bus.misaligned !== rows[i].em ||
                    bus.instruction !== exp_instr(rows[i].ev, rows[i].epc) ||
                    (rows[i].ev && (bus.pc !== rows[i].epc || bus.pc_plus4 !== rows[i].epc + 32'd4)))
                    $display("FAIL misaligned row %0d: valid=%b pc=%h instr=%h mis=%b, want valid=%b pc=%h instr=%h mis=%b",
                             i, bus.instr_valid, bus.pc, bus.instruction, bus.misaligned,
                             rows[i].ev, rows[i].epc, exp_instr(rows[i].ev, rows[i].epc), rows[i].em);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        row_t rows[$];
        rows.push_back(mk(1, 0, 0, 32'h0,  0, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 1, 32'h20, 1, 1, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 0, 32'h0,  0));
        rows.push_back(mk(0, 1, 0, 32'h0,  1, 1, 32'h20, 0));
        rows.push_back(mk(1, 1, 0, 32'h0,  1, 1, 32'h20, 0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 0, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h0,  0));
        rows.push_back(mk(0, 0, 0, 32'h0,  1, 1, 32'h4,  0));
        foreach (rows[i]) begin
            drive(rows[i].rst, rows[i].st, rows[i].bt, rows[i].tgt);
            if (rows[i].chk) begin
                checks++;
                if (bus.instr_valid !== rows[i].ev || bus.misaligned !== rows[i].em ||
                    bus.instruction !== exp_instr(rows[i].ev, rows[i].epc) ||
                    (rows[i].ev && (bus.pc !== rows[i].epc || bus.pc_plus4 !== rows[i].epc + 32'd4)))
                    $display("FAIL reset_mid_stall row %0d: valid=%b pc=%h instr=%h mis=%b, want valid=%b pc=%h instr=%h mis=%b",
                             i, bus.instr_valid, bus.pc, bus.instruction, bus.misaligned,
                             rows[i].ev, rows[i].epc, exp_instr(rows[i].ev, rows[i].epc), rows[i].em);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        row_t rows[$];
        rows.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0));
        rows.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,         0));
        rows.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h0,         0));
        rows.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,         0));
        rows.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0));
        rows.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h0,         0));
        rows.push_back(mk(0, 0, 1, 32'h0001_0000, 1, 1, 32'h4,         0));
        rows.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,         0));
        rows.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h0001_0000, 0));
        rows.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h0001_0004, 0));
        foreach (rows[i]) begin
            drive(rows[i].rst, rows[i].st, rows[i].bt, rows[i].tgt);
            if (rows[i].chk) begin
                checks++;
                if (bus.instr_valid !== rows[i].ev || bus.misaligned !== rows[i].em ||
                    bus.instruction !== exp_instr(rows[i].ev, rows[i].epc) ||
                    (rows[i].ev && (bus.pc !== rows[i].epc || bus.pc_plus4 !== rows[i].epc + 32'd4)))
                    $display("FAIL wrap row %0d: valid=%b pc=%h instr=%h mis=%b, want valid=%b pc=%h instr=%h mis=%b",
                             i, bus.instr_valid, bus.pc, bus.instruction, bus.misaligned,
                             rows[i].ev, rows[i].epc, exp_instr(rows[i].ev, rows[i].epc), rows[i].em);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        drive(1, 0, 0, 32'h0);
        tick();
        model_step();
        for (int n = 0; n < 400; n++) begin
            tgt = $urandom();
            if ($urandom_range(0, 99) < 70) tgt[1:0] = 2'b00;
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 25, tgt);
            checks++;
            if (bus.instr_valid !== m_valid || bus.misaligned !== m_mis ||
                bus.instruction !== exp_instr(m_valid, m_pc) ||
                (m_valid && (bus.pc !== m_pc || bus.pc_plus4 !== m_pc + 32'd4)))
                $display("FAIL random cycle %0d: valid=%b pc=%h instr=%h mis=%b, want valid=%b pc=%h instr=%h mis=%b",
                         n, bus.instr_valid, bus.pc, bus.instruction, bus.misaligned,
                         m_valid, m_pc, exp_instr(m_valid, m_pc), m_mis);
            else passes++;
            tick();
            model_step();
        end
    endtask

    initial begin
        clk     = 1'b0;
        checks  = 0;
        passes  = 0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_pc    = 32'h0;
        m_next  = 32'h0;
        for (int k = 0; k < (1 << AW); k++) rom[k] = 32'hA000_0000 | 32'(k);
        drive(1, 0, 0, 32'h0);
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_stall_branch();
        test_misaligned();
        test_reset_mid_stall();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder / register-file block.
- Owns the program counter and drives a synchronous instruction ROM with 1-cycle read latency.
- Presents {instruction, pc, pc_plus4, instr_valid} to decode.
- Supports downstream stall with a holding register (no lost/duplicated words) and branch/jump redirect with a one-cycle bubble.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
IMEM_AW, 14, ROM word-address width (ROM depth = 2^IMEM_AW words)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high; dominates every other input
stall  input  1  decode/execute not ready; hold current instruction
branch_taken  input  1  redirect request for the currently presented instruction
branch_target  input  32  redirect byte address
imem_addr  output  IMEM_AW  word address to ROM; combinational = fpc[IMEM_AW+1:2]
imem_rdata  input  32  ROM data for the address presented on the previous cycle
instruction  output  32  current instruction = hold_valid ? hold_instr : imem_rdata; 32'h0000_0013 (NOP) when instr_valid=0
pc  output  32  byte address of current instruction
pc_plus4  output  32  pc + 4, mod 2^32 (link value for jal/jalr)
instr_valid  output  1  instruction/pc are meaningful
misaligned  output  1  sticky: an accepted redirect had branch_target[1:0] != 0

Behaviour:
- Internal state:
  - fpc: address being presented to the ROM this cycle.
  - pc: address whose word is returning.
  - hold_instr, hold_valid.
  - state in {FILL, RUN}.
- Reset, the cycle after reset is high:
  - fpc = RESET_PC, pc = RESET_PC, state = FILL.
  - instr_valid = 0, hold_valid = 0, hold_instr = 0, misaligned = 0.
  - instruction = NOP.
- FILL:
  - instr_valid = 0; stall and branch_taken are ignored.
  - Next cycle: pc <= fpc, fpc <= fpc+4, state <= RUN.
- RUN, !stall, !branch_taken:
  - instr_valid = 1 (word consumed).
  - Next cycle: pc <= fpc, fpc <= fpc+4, hold_valid <= 0.
  - Steady-state throughput: 1 instruction/cycle.
- RUN, stall:
  - pc and fpc are held; instr_valid stays 1.
  - First stall cycle with hold_valid=0: hold_instr <= imem_rdata, hold_valid <= 1.
  - Later stall cycles leave hold unchanged, so the instruction output is stable for the whole stall.
  - imem_addr stays at fpc, so on release the ROM already returns mem[fpc] and no bubble is inserted.
- RUN, !stall, branch_taken (accepted redirect):
  - fpc <= {branch_target[31:2], 2'b00}, hold_valid <= 0, state <= FILL.
  - If branch_target[1:0] != 0, misaligned <= 1.
  - The word returning in the next cycle is wrong-path and is discarded (instr_valid = 0).
  - Redirect penalty is exactly 1 bubble: accept in cycle N, FILL in N+1, valid target instruction in N+2.
- Simultaneous stall and branch_taken: stall wins and the redirect is not accepted. The consumer must keep branch_taken asserted until the stall drops.
- Wrap-around:
  - fpc+4 and pc+4 wrap modulo 2^32.
  - imem_addr truncation aliases the ROM (e.g. IMEM_AW=14: byte 32'h0001_0000 maps to word 0).
- misaligned is cleared only by reset.
- Reset mid-stall or mid-FILL aborts immediately: hold is dropped and fetch restarts at RESET_PC.
- No combinational path from stall/branch_* to imem_addr (imem_addr depends on registers only).

Test Plan:
ROM preloaded mem[k] = 32'hA000_0000 | k.
- Reset release, stall=0 for 5 cycles:
  - instr_valid is 0 in the first cycle.
  - Then pc = 0,4,8,12 with instruction = A0000000, A0000001, A0000002, A0000003.
  - pc_plus4 = pc+4.
- Stall while pc=8 for 3 cycles:
  - instruction stays A0000002 and pc stays 8 through all stall cycles.
  - On release the next cycle gives pc=12 / A0000003, with no gap and no repeat.
- branch_taken=1, branch_target=32'h40 accepted while pc=4:
  - Exactly one cycle with instr_valid=0.
  - Then pc=0x40 / A0000010, followed by 0x44 / A0000011.
- stall=1 and branch_taken=1 together for 2 cycles, then stall=0 with branch held for one more cycle:
  - No redirect during the stall.
  - Redirect accepted on the release cycle, then one bubble, then the target word.
- Redirect to branch_target=32'h0000_0042:
  - misaligned becomes 1 and pc becomes 0x40.
  - misaligned stays 1 through later normal fetches and clears only on reset.
- reset asserted during a 2-cycle stall at pc=0x20:
  - Next cycle instr_valid=0 and hold is cleared.
  - Fetch restarts at pc=0 / A0000000.
- Optional extra: fetch past ROM end with IMEM_AW=4: pc=0x40 returns A0000000 (alias).
